// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame painter's-order sequencer for the shared framebuffer write bus
module frame_draw_scheduler #(
    parameter int NUM_SOURCES   = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame_start,
    input  logic [NUM_SOURCES-1:0] source_enable,
    input  logic                   write_active,
    output logic [SEL_WIDTH-1:0]   write_source_sel,
    output logic                   write_awaited,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_overrun,
    output logic [NUM_SOURCES-1:0] timeout_err
);

    localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE, SELECT, TRIGGER, WAIT_START, WAIT_END, ADVANCE, DONE
    } state_t;

    state_t                 state;
    logic [NUM_SOURCES-1:0] mask_q;
    logic [NUM_SOURCES-1:0] mask_left;
    logic [SEL_WIDTH-1:0]   idx;
    logic [CNT_W-1:0]       cnt;

    function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [NUM_SOURCES-1:0] m);
        logic [SEL_WIDTH-1:0] r;
        r = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_WIDTH'(i);
        end
        return r;
    endfunction

    always_comb begin
        mask_left      = mask_q;
        mask_left[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            write_source_sel <= '0;
            write_awaited    <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            frame_overrun    <= 1'b0;
            timeout_err      <= '0;
            mask_q           <= '0;
            idx              <= '0;
            cnt              <= '0;
        end else begin
            write_awaited <= 1'b0;
            // Requests outside IDLE (DONE included) are dropped and flagged.
            frame_overrun <= frame_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        mask_q <= source_enable;
                        if (source_enable == '0) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx   <= lowest_set(source_enable);
                            busy  <= 1'b1;
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    write_source_sel <= idx;
                    write_awaited    <= 1'b1;
                    state            <= TRIGGER;
                end
                TRIGGER: begin
                    cnt   <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (write_active) begin
                        state <= WAIT_END;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        timeout_err[idx] <= 1'b1;
                        state            <= ADVANCE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // No timeout here: a full-screen burst is legitimately very long.
                WAIT_END: begin
                    if (!write_active) state <= ADVANCE;
                end
                ADVANCE: begin
                    mask_q <= mask_left;
                    if (mask_left != '0) begin
                        idx   <= lowest_set(mask_left);
                        state <= SELECT;
                    end else begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - randomized self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;

    localparam int NS = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          frame_start = 1'b0;
    logic [NS-1:0] source_enable = '0;
    logic          write_active = 1'b0;
    logic [1:0]    write_source_sel;
    logic          write_awaited;
    logic          busy;
    logic          frame_done;
    logic          frame_overrun;
    logic [NS-1:0] timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    int src_lat    [NS];
    int src_len    [NS];
    bit src_silent [NS];
    logic [NS-1:0] exp_err = '0;

    frame_draw_scheduler #(.NUM_SOURCES(NS), .SEL_WIDTH(2), .START_TIMEOUT(TO)) dut (
        .clk              (clk),
        .resetN           (resetN),
        .frame_start      (frame_start),
        .source_enable    (source_enable),
        .write_active     (write_active),
        .write_source_sel (write_source_sel),
        .write_awaited    (write_awaited),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_overrun    (frame_overrun),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Draw-source behaviour: answers a trigger after lat cycles, bursts for len cycles.
    initial begin
        int pend = 0;
        int rem  = 0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                write_active = 1'b0;
                pend = 0;
                rem  = 0;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) write_active = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    write_active = 1'b1;
                    rem = src_len[write_source_sel];
                end
            end else if (write_awaited && !src_silent[write_source_sel]) begin
                pend = src_lat[write_source_sel];
            end
        end
    end

    // mode 0: plain frame, 1: frame_start injected mid-burst and in DONE, 2: reset in source 1 burst
    task automatic run_frame(input logic [NS-1:0] mask, input int mode);
        int exp_ids[$];
        int got_ids[$];
        int exp_busy = 0;
        int bcyc = 0;
        int novr = 0;
        int act_cnt = 0;
        int budget = 3000;
        int extra_busy = 0;
        for (int i = 0; i < NS; i++) begin
            if (mask[i]) begin
                exp_ids.push_back(i);
                exp_busy += src_silent[i] ? (3 + TO) : (3 + src_lat[i] + src_len[i]);
                if (src_silent[i]) exp_err[i] = 1'b1;
            end
        end
        @(negedge clk);
        source_enable = mask;
        frame_start   = 1'b1;
        @(negedge clk);
        frame_start   = 1'b0;
        source_enable = $urandom_range(0, 15);
        if (mask == '0) begin
            chk("empty_done_t1", frame_done, 1);
            chk("empty_busy", busy, 0);
        end
        while (!frame_done && budget > 0) begin
            if (frame_start) frame_start = 1'b0;
            if (frame_overrun) novr++;
            if (busy) bcyc++;
            if (write_awaited) got_ids.push_back(int'(write_source_sel));
            if (mode != 0 && write_source_sel == 2'd1 && write_active) begin
                act_cnt++;
                if (act_cnt == 3 && mode == 1) frame_start = 1'b1;
                if (act_cnt == 3 && mode == 2) begin
                    resetN = 1'b0;
                    #1;
                    chk("rst_sel", write_source_sel, 0);
                    chk("rst_awaited", write_awaited, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", frame_done, 0);
                    chk("rst_overrun", frame_overrun, 0);
                    chk("rst_err", timeout_err, 0);
                    exp_err = '0;
                    @(negedge clk);
                    @(negedge clk);
                    chk("rst_no_done", frame_done, 0);
                    resetN = 1'b1;
                    return;
                end
            end
            @(negedge clk);
            budget--;
        end
        chk("frame_done_seen", budget > 0, 1);
        chk("busy_low_at_done", busy, 0);
        chk("busy_cycles", bcyc, exp_busy);
        chk("trigger_count", got_ids.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++)
            chk("trigger_order", got_ids[i], exp_ids[i]);
        chk("timeout_err", timeout_err, exp_err);
        if (mask != '0) chk("sel_hold", write_source_sel, exp_ids[exp_ids.size() - 1]);
        if (mode == 1) frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (frame_overrun) novr++;
        chk("done_one_cycle", frame_done, 0);
        for (int i = 0; i < 6; i++) begin
            if (busy || frame_done) extra_busy++;
            @(negedge clk);
        end
        chk("no_extra_frame", extra_busy, 0);
        chk("overrun_count", novr, (mode == 1) ? 2 : 0);
        if (mask != '0) chk("sel_hold_idle", write_source_sel, exp_ids[exp_ids.size() - 1]);
    endtask

    task automatic set_all(input int lat, input int len);
        for (int i = 0; i < NS; i++) begin
            src_lat[i] = lat;
            src_len[i] = len;
            src_silent[i] = 1'b0;
        end
    endtask

    initial begin
        set_all(2, 10);
        #1;
        chk("reset_sel", write_source_sel, 0);
        chk("reset_awaited", write_awaited, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_overrun", frame_overrun, 0);
        chk("reset_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        run_frame(4'b1111, 0);
        run_frame(4'b1010, 0);
        run_frame(4'b0000, 0);
        src_silent[2] = 1'b1;
        run_frame(4'b1111, 0);
        chk("timeout_src2", timeout_err, 4'b0100);
        src_silent[2] = 1'b0;
        run_frame(4'b1111, 1);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NS; i++) begin
                src_lat[i]    = $urandom_range(1, 3);
                src_len[i]    = $urandom_range(1, 12);
                src_silent[i] = ($urandom_range(0, 5) == 0);
            end
            run_frame(4'($urandom_range(0, 15)), 0);
        end

        set_all(2, 30);
        run_frame(4'b1111, 2);
        set_all(2, 10);
        run_frame(4'b1111, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_draw_scheduler.md
# frame_draw_scheduler

Sequences the framebuffer's draw sources once per frame. On each `frame_start` it hands the shared write bus to every enabled source in ascending ID order, so background first and overlays last (painter's order). For each source it drives `write_source_sel`, issues a one-cycle `write_awaited` trigger, and waits for that source's `write_active` burst to start and finish before moving on. It sits between the display/buffer-swap logic and the tri-state write bus shared by all draw sources.

## Interface
- NUM_SOURCES, 4, number of draw sources on the bus (IDs 0..NUM_SOURCES-1)
- SEL_WIDTH, 2, width of `write_source_sel`; must satisfy 2^SEL_WIDTH >= NUM_SOURCES
- START_TIMEOUT, 16, max cycles to wait for `write_active` to rise after the trigger
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle pulse requesting a full frame redraw
- source_enable  in  NUM_SOURCES  per-source enable; sampled only at frame accept
- write_active  in  1  shared bus; driven by the selected source
- write_source_sel  out  SEL_WIDTH  ID of the source that owns the bus
- write_awaited  out  1  one-cycle trigger to the selected source
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse when all enabled sources have finished
- frame_overrun  out  1  one-cycle pulse when `frame_start` arrives while busy
- timeout_err  out  NUM_SOURCES  sticky per-source flag: source never started; cleared only by reset

## Operation
- States: IDLE, SELECT, TRIGGER, WAIT_START, WAIT_END, ADVANCE, DONE.
- **IDLE**
  - On `frame_start`, latch `source_enable` into `mask_q`.
  - If `mask_q` is zero, go to DONE. Otherwise set `idx` to the lowest set bit and go to SELECT.
- **SELECT**
  - `write_source_sel` <= `idx`.
  - Stays one cycle so the bus can settle. Next state is TRIGGER.
- **TRIGGER**
  - `write_awaited` = 1 for exactly this cycle.
  - Clears the timeout counter. Next state is WAIT_START.
- **WAIT_START**
  - If `write_active` = 1, go to WAIT_END.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT-1, set `timeout_err[idx]` and go to ADVANCE.
- **WAIT_END**
  - Stays while `write_active` = 1. Has no timeout, because a full-screen source legitimately runs about 307200 cycles.
  - On `write_active` = 0, go to ADVANCE.
- **ADVANCE**
  - Clear `mask_q[idx]`.
  - If any bit remains, set `idx` to the next lowest set bit and go to SELECT. Otherwise go to DONE.
- **DONE**
  - `frame_done` = 1 for one cycle, then go to IDLE.
- **Selection hold**
  - `write_source_sel` holds its last value in IDLE and DONE; it never changes outside SELECT.
  - The selected source therefore keeps driving `write_active` and its address/data lines; other sources stay in 'z.
- **Frame-start rules**
  - `frame_start` in any state other than IDLE produces a one-cycle `frame_overrun` pulse. The request is dropped, not queued.
  - `frame_start` in the same cycle as DONE is also an overrun.
- **Enable rules**
  - Changes to `source_enable` while busy have no effect until the next accepted frame.
- `busy` = (state != IDLE && state != DONE).

## Timing
- **Reset values** (asynchronous, all registers): state IDLE, `write_source_sel` 0, `write_awaited` 0, `busy` 0, `frame_done` 0, `frame_overrun` 0, `timeout_err` all 0, `mask_q` 0, `idx` 0, counter 0.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs. `frame_overrun` is registered, so it appears one cycle after the offending `frame_start`.
- **Normal frame sequence**, with `frame_start` sampled at edge T:
  - SELECT in cycle T+1: `busy` = 1, `write_source_sel` updates at edge T+2.
  - TRIGGER in cycle T+2: `write_awaited` = 1.
  - The source moves to its ACTIVATE state at T+3 and to its active state at T+4.
  - `write_active` is seen at edge T+4, so WAIT_END starts at T+5.
- **Per-source overhead** outside the burst: SELECT + TRIGGER + ADVANCE, plus the 1-2 cycle source start latency.
- **Done timing**: `frame_done` asserts the cycle after the last ADVANCE. `busy` falls in that same cycle.
- **Empty mask**: `frame_start` at T gives `frame_done` = 1 in cycle T+1 and `busy` never rises.
- **Timeout**: a source that never answers costs 3 + START_TIMEOUT cycles. The schedule then continues with the next source.
- **Mid-frame reset**: all outputs return to reset values immediately. `write_awaited` drops and the frame is abandoned; there is no `frame_done`.

## Test plan
- Mask 4'b1111; each source model raises `write_active` 2 cycles after its trigger and holds it 10 cycles -> `write_source_sel` steps 0,1,2,3, four `write_awaited` pulses, one `frame_done`, `timeout_err` = 0.
- Mask 4'b1010 -> only sources 1 and 3 are selected, each triggered once, then `frame_done`.
- Mask 0 -> `frame_done` exactly one cycle after `frame_start`; `busy` stays 0.
- Source 2 is silent with START_TIMEOUT = 16 -> `timeout_err` = 4'b0100 after 16 WAIT_START cycles; source 3 still runs and `frame_done` asserts.
- `frame_start` pulsed during source 1's burst, and again in the DONE cycle -> two `frame_overrun` pulses; the schedule is unaffected and no extra frame runs.
- `resetN` low during WAIT_END of source 1 -> all outputs at reset values asynchronously; the next `frame_start` runs a clean frame from source 0.
